// File: rtl/axi_slv_pkg.sv
// Shared constants and state type for the AXI4-to-SRAM slave.
package axi_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAP   = 3'd2,
    ST_R_DATA   = 3'd3,
    ST_W_DATA   = 3'd4,
    ST_B_RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 read/write channel bundle between the interconnect (master) and the SRAM slave.
interface axi_sram_slave_if #(
  parameter int unsigned ID_W = 8
) ();

  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;

  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;

  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;

  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/axi_burst_ctr.sv
// Burst bookkeeping: latched word address, LEN and beat counter; address wraps at top of memory.
module axi_burst_ctr
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [3:0]        load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              is_last
);

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        beat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (load) begin
      addr_q <= load_addr;
      len_q  <= load_len;
      beat_q <= '0;
    end else if (step) begin
      addr_q <= addr_q + ADDR_W'(1);
      beat_q <= beat_q + 4'd1;
    end
  end

  assign addr    = addr_q;
  assign is_last = (beat_q == len_q);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave serving INCR bursts from a 1-cycle-latency single-port SRAM.
// Define AXI_SRAM_ADDR_CHECK_EN to answer SLVERR for beats above the SRAM range.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  axi_sram_slave_if.slave   bus,
  output logic              CS,
  output logic              OE,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       rdata_q;
  logic              err_q, err_d;
  logic              oor_q;
  logic              ld, step, is_last;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       ld_byte_addr;
  logic [3:0]        ld_len;
  logic [ID_W-1:0]   ld_id;
  logic              unused_ok;

  axi_burst_ctr #(
    .ADDR_W (ADDR_W)
  ) u_burst_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .step      (step),
    .load_addr (ld_byte_addr[ADDR_W+1:2]),
    .load_len  (ld_len),
    .addr      (addr),
    .is_last   (is_last)
  );

  // Read has priority, so the load mux follows ARVALID.
  assign ld_byte_addr = bus.ARVALID ? bus.ARADDR : bus.AWADDR;
  assign ld_len       = bus.ARVALID ? bus.ARLEN  : bus.AWLEN;
  assign ld_id        = bus.ARVALID ? bus.ARID   : bus.AWID;

`ifdef AXI_SRAM_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else if (ld) begin
      oor_q <= |ld_byte_addr[31:ADDR_W+2];
    end
  end
`else
  assign oor_q = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    ld          = 1'b0;
    step        = 1'b0;
    CS          = 1'b0;
    OE          = 1'b0;
    WEB         = 4'hF;
    A           = '0;
    DI          = '0;
    bus.ARREADY = 1'b0;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    bus.BID     = '0;
    bus.BRESP   = RESP_OKAY;
    bus.RVALID  = 1'b0;
    bus.RID     = '0;
    bus.RDATA   = '0;
    bus.RRESP   = RESP_OKAY;
    bus.RLAST   = 1'b0;
    // Outputs stay at their idle values for the whole reset cycle.
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          bus.ARREADY = bus.ARVALID;
          bus.AWREADY = bus.AWVALID & ~bus.ARVALID;
          if (bus.ARVALID) begin
            ld      = 1'b1;
            err_d   = 1'b0;
            state_d = ST_RD_ISSUE;
          end else if (bus.AWVALID) begin
            ld      = 1'b1;
            err_d   = 1'b0;
            state_d = ST_W_DATA;
          end
        end
        ST_RD_ISSUE: begin
          CS      = ~oor_q;
          OE      = 1'b1;
          A       = addr;
          state_d = ST_RD_CAP;
        end
        ST_RD_CAP: begin
          OE      = 1'b1;
          state_d = ST_R_DATA;
        end
        ST_R_DATA: begin
          bus.RVALID = 1'b1;
          bus.RDATA  = rdata_q;
          bus.RID    = id_q;
          bus.RLAST  = is_last;
          bus.RRESP  = oor_q ? RESP_SLVERR : RESP_OKAY;
          if (bus.RREADY) begin
            if (is_last) begin
              state_d = ST_IDLE;
            end else begin
              step    = 1'b1;
              state_d = ST_RD_ISSUE;
            end
          end
        end
        ST_W_DATA: begin
          bus.WREADY = 1'b1;
          if (bus.WVALID) begin
            CS   = 1'b1;
            WEB  = oor_q ? 4'hF : ~bus.WSTRB;
            DI   = bus.WDATA;
            A    = addr;
            step = 1'b1;
            if ((bus.WLAST != is_last) || oor_q) err_d = 1'b1;
            if (bus.WLAST || is_last) state_d = ST_B_RESP;
          end
        end
        ST_B_RESP: begin
          bus.BVALID = 1'b1;
          bus.BID    = id_q;
          bus.BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
          if (bus.BREADY) begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (ld) id_q <= ld_id;
      if (state_q == ST_RD_CAP) rdata_q <= oor_q ? '0 : DO;
    end
  end

  // Size/burst are fixed by the system; byte-lane and upper address bits only matter with the check.
  assign unused_ok = ^{bus.AWSIZE ^ SIZE_WORD, bus.ARSIZE ^ SIZE_WORD,
                       bus.AWBURST ^ BURST_INCR, bus.ARBURST ^ BURST_INCR,
                       ld_byte_addr[31:ADDR_W+2], ld_byte_addr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized self-checking bench for axi_sram_slave with a transaction-level memory model.
module tb_axi_sram_slave;
  import axi_slv_pkg::*;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef AXI_SRAM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              CS, OE;
  logic [3:0]        WEB;
  logic [ADDR_W-1:0] A;
  logic [31:0]       DI;
  logic [31:0]       DO = '0;

  axi_sram_slave_if #(.ID_W(ID_W)) bus ();

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .CS  (CS),
    .OE  (OE),
    .WEB (WEB),
    .A   (A),
    .DI  (DI),
    .DO  (DO)
  );

  always #5 clk = ~clk;

  // SRAM macro: the environment the DUT drives.
  logic [31:0] sram    [DEPTH];
  // Reference memory: updated only from transaction-level rules.
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (CS) begin
      if (WEB == 4'hF) DO <= sram[A];
      else for (int i = 0; i < 4; i++) if (!WEB[i]) sram[A][8*i +: 8] <= DI[8*i +: 8];
    end
  end

  typedef struct { logic [7:0] id; logic [31:0] data; logic last; logic [1:0] resp; } r_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [3:0] web; logic [31:0] data; } w_exp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;

  r_exp_t exp_r[$];
  w_exp_t exp_w[$];
  b_exp_t exp_b[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] got [16];
  logic [1:0]  got_resp [16];
  logic [1:0]  got_bresp;
  time         ar_hs_t, aw_hs_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] word_at(input logic [31:0] a, input int b);
    logic [ADDR_W-1:0] w;
    w = a[ADDR_W+1:2];
    return w + ADDR_W'(b);
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    return CHECK_EN && (a[31:ADDR_W+2] != '0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    sram[word_at(byte_addr, 0)]    = data;
    ref_mem[word_at(byte_addr, 0)] = data;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input int stall);
    int     cnt;
    r_exp_t e;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
    bus.ARSIZE = SIZE_WORD; bus.ARBURST = BURST_INCR; bus.ARVALID = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!bus.ARREADY && cnt < 100) begin @(negedge clk); cnt++; end
    check("ar_handshake", bus.ARREADY, 1);
    if (!bus.ARREADY) begin bus.ARVALID = 1'b0; return; end
    @(posedge clk);
    ar_hs_t = $time;
    #1;
    bus.ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.data = is_oor(addr) ? 32'h0 : ref_mem[word_at(addr, b)];
      e.last = (b == int'(len));
      e.resp = is_oor(addr) ? RESP_SLVERR : RESP_OKAY;
      exp_r.push_back(e);
    end
    // Count edges from the handshake edge (inclusive) until RVALID is seen.
    cnt = 1;
    for (int b = 0; b <= int'(len); b++) begin
      while (!bus.RVALID && cnt < 20) begin tick(); cnt++; end
      check("rd_latency", cnt, 3);
      if (!bus.RVALID) return;
      got[b]      = bus.RDATA;
      got_resp[b] = bus.RRESP;
      repeat (stall) tick();
      bus.RREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0;
      cnt = 1;
    end
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int wlast_at, input int stall);
    int     cnt, nb;
    bit     err;
    w_exp_t e;
    b_exp_t eb;
    nb  = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
    err = (wlast_at != int'(len)) || is_oor(addr);
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    bus.AWSIZE = SIZE_WORD; bus.AWBURST = BURST_INCR; bus.AWVALID = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!bus.AWREADY && cnt < 100) begin @(negedge clk); cnt++; end
    check("aw_handshake", bus.AWREADY, 1);
    if (!bus.AWREADY) begin bus.AWVALID = 1'b0; return; end
    @(posedge clk);
    aw_hs_t = $time;
    #1;
    bus.AWVALID = 1'b0;
    for (int b = 0; b < nb; b++) begin
      e.addr = word_at(addr, b);
      e.web  = is_oor(addr) ? 4'hF : ~ws[b];
      e.data = wd[b];
      exp_w.push_back(e);
      if (!is_oor(addr))
        for (int i = 0; i < 4; i++) if (ws[b][i]) ref_mem[e.addr][8*i +: 8] = wd[b][8*i +: 8];
    end
    eb.id   = id;
    eb.resp = err ? RESP_SLVERR : RESP_OKAY;
    exp_b.push_back(eb);
    for (int b = 0; b < nb; b++) begin
      bus.WVALID = 1'b1; bus.WDATA = wd[b]; bus.WSTRB = ws[b]; bus.WLAST = (b == wlast_at);
      cnt = 0;
      @(negedge clk);
      while (!bus.WREADY && cnt < 20) begin @(negedge clk); cnt++; end
      check("w_ready", bus.WREADY, 1);
      @(posedge clk);
      #1;
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    cnt = 0;
    while (!bus.BVALID && cnt < 20) begin tick(); cnt++; end
    check("b_valid", bus.BVALID, 1);
    got_bresp = bus.BRESP;
    repeat (stall) tick();
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
  endtask

  // Compare process: every R/W/B handshake against the model, plus hold-stability under stalls.
  logic        prev_rv, prev_rr, prev_bv, prev_br;
  logic [42:0] prev_r;
  logic [9:0]  prev_b;
  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0; prev_rr = 1'b0; prev_bv = 1'b0; prev_br = 1'b0;
    end else begin
      if (bus.RVALID) begin
        if (prev_rv && !prev_rr)
          check("r_stable", {bus.RDATA, bus.RID, bus.RLAST, bus.RRESP}, prev_r);
        if (bus.RREADY) begin
          if (exp_r.size() == 0) check("r_unexpected", 1, 0);
          else begin
            check("rdata", bus.RDATA, exp_r[0].data);
            check("rid",   bus.RID,   exp_r[0].id);
            check("rlast", bus.RLAST, exp_r[0].last);
            check("rresp", bus.RRESP, exp_r[0].resp);
            void'(exp_r.pop_front());
          end
        end
      end
      if (bus.WVALID && bus.WREADY) begin
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else begin
          check("w_cs",  CS,  1);
          check("w_web", WEB, exp_w[0].web);
          check("w_a",   A,   exp_w[0].addr);
          check("w_di",  DI,  exp_w[0].data);
          void'(exp_w.pop_front());
        end
      end
      if (bus.BVALID) begin
        if (prev_bv && !prev_br) check("b_stable", {bus.BID, bus.BRESP}, prev_b);
        if (bus.BREADY) begin
          if (exp_b.size() == 0) check("b_unexpected", 1, 0);
          else begin
            check("bid",   bus.BID,   exp_b[0].id);
            check("bresp", bus.BRESP, exp_b[0].resp);
            void'(exp_b.pop_front());
          end
        end
      end
      prev_rv = bus.RVALID; prev_rr = bus.RREADY;
      prev_r  = {bus.RDATA, bus.RID, bus.RLAST, bus.RRESP};
      prev_bv = bus.BVALID; prev_br = bus.BREADY;
      prev_b  = {bus.BID, bus.BRESP};
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, bus.ARREADY, 0);
    check({tag, "_awready"}, bus.AWREADY, 0);
    check({tag, "_wready"},  bus.WREADY,  0);
    check({tag, "_rvalid"},  bus.RVALID,  0);
    check({tag, "_bvalid"},  bus.BVALID,  0);
    check({tag, "_cs_oe"},   {CS, OE},    0);
    check({tag, "_web"},     WEB,         4'hF);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          len, wl;
    for (int i = 0; i < int'(DEPTH); i++) begin sram[i] = '0; ref_mem[i] = '0; end
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.RREADY = 1'b0;
    // Reset with both address channels requesting: nothing may be accepted.
    rst = 1'b1; bus.ARVALID = 1'b1; bus.AWVALID = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    #1;
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single read.
    preload(32'h40, 32'hDEADBEEF);
    do_read(8'h05, 32'h40, 4'd0, 0);
    check("single_read_data", got[0], 32'hDEADBEEF);

    // Burst write then burst read.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(8'h11, 32'h100, 4'd3, 3, 0);
    check("burst_write_bresp", got_bresp, RESP_OKAY);
    do_read(8'h12, 32'h100, 4'd3, 0);
    for (int i = 0; i < 4; i++) check("burst_read_data", got[i], 32'(i + 1));

    // Byte strobes.
    preload(32'h200, 32'h11223344);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(8'h13, 32'h200, 4'd0, 0, 0);
    do_read(8'h14, 32'h200, 4'd0, 0);
    check("strobe_merge", got[0], 32'h11BB33DD);

    // Simultaneous AR/AW to one word: the read must see the old value.
    preload(32'h300, 32'hCAFE0000);
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    fork
      do_read(8'h21, 32'h300, 4'd0, 0);
      do_write(8'h22, 32'h300, 4'd0, 0, 0);
    join
    check("arb_read_first", got[0], 32'hCAFE0000);
    check("arb_order", (ar_hs_t < aw_hs_t), 1);
    do_read(8'h23, 32'h300, 4'd0, 5);
    check("arb_write_landed", got[0], 32'h12345678);

    // Backpressure on B, early WLAST error, wrap at top of memory.
    do_write(8'h31, 32'h400, 4'd2, 2, 3);
    do_write(8'h32, 32'h500, 4'd1, 0, 0);
    check("early_wlast_bresp", got_bresp, RESP_SLVERR);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(8'h33, (DEPTH - 2) * 4, 4'd3, 3, 0);
    do_read(8'h34, 32'h0, 4'd1, 0);
    check("wrap_word0", got[0], 32'hA2);
    check("wrap_word1", got[1], 32'hA3);

`ifdef AXI_SRAM_ADDR_CHECK_EN
    do_read(8'h41, 32'h0001_0000, 4'd0, 0);
    check("oor_rdata", got[0], 32'h0);
    check("oor_rresp", got_resp[0], RESP_SLVERR);
`else
    do_read(8'h41, 32'h0001_0040, 4'd0, 0);
    check("alias_rdata", got[0], 32'hDEADBEEF);
`endif

    // Reset while a read beat is waiting in R_DATA: beat dropped, outputs idle.
    bus.ARID = 8'h77; bus.ARADDR = 32'h40; bus.ARLEN = 4'd2; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    repeat (2) tick();
    check("pre_reset_rvalid", bus.RVALID, 1);
    rst = 1'b1; bus.AWVALID = 1'b1;
    tick();
    @(negedge clk);
    check_idle_outputs("rdata_reset");
    #1;
    bus.AWVALID = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_reset_rvalid", bus.RVALID, 0);

    // Randomized mix of reads and writes.
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[ADDR_W+1:2] = ADDR_W'(DEPTH - 1 - $urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) a[31:ADDR_W+2] = '0;
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        wl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : len;
        do_write(8'($urandom), a, 4'(len), wl, $urandom_range(0, 2));
      end else begin
        do_read(8'($urandom), a, 4'(len), $urandom_range(0, 2));
      end
    end

    repeat (3) tick();
    check("r_queue_drained", exp_r.size(), 0);
    check("w_queue_drained", exp_w.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
